// File: rtl/ssf_bank_ctrl.sv
// SSF mapper bank-register controller: synchronised /TIME write qualification, seven slot
// registers and the SRAM control register. Optional write-protect via SSF_SRAM_WP_EN.
module ssf_bank_ctrl #(
  parameter int unsigned BANK_W         = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned RESET_IDENTITY = 1
) (
  input  logic              vclk,
  input  logic              vres,
  input  logic              tme,
  input  logic              lwr,
  input  logic [22:0]       cart_address,
  input  logic [7:0]        cart_data_lo,
  output logic [BANK_W-1:0] rom_bank,
  output logic              sram_en,
  output logic              bank_wr_stb,
  output logic [2:0]        bank_wr_idx,
  output logic              busy
`ifdef SSF_SRAM_WP_EN
  ,
  output logic              sram_wp
`endif
);

`ifdef SSF_SRAM_WP_EN
  localparam int unsigned CtrlW = 2;
`else
  localparam int unsigned CtrlW = 1;
`endif

  typedef enum logic [1:0] {StIdle, StQual, StCommit, StRelease} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   stb_q, stb_d;
  logic [CtrlW-1:0]       ctrl_q, ctrl_d;
  logic [BANK_W-1:0]      slot_q [1:7];
  logic [BANK_W-1:0]      slot_d [1:7];

  logic wr_req, wr_s, commit_we, locked;
  logic [2:0] slot_sel;
  logic unused_bits;

  assign wr_req   = ~tme & ~lwr;
  assign wr_s     = sync_q[SYNC_STAGES-1];
  assign slot_sel = cart_address[20:18];
  assign unused_bits = ^{cart_address[22:21], cart_address[17:7], data_q};

`ifdef SSF_SRAM_WP_EN
  // The control register itself stays writable so the lock can be lifted.
  assign locked  = ctrl_q[1] && (idx_q != 3'd0);
  assign sram_wp = ctrl_q[1];
`else
  assign locked  = 1'b0;
`endif

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], wr_req};
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    valid_d   = valid_q;
    commit_we = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wr_s) state_d = StQual;
      end
      StQual: begin
        // Strobe must survive two synced samples; otherwise treat it as a glitch.
        if (wr_s) begin
          idx_d   = cart_address[2:0];
          data_d  = cart_data_lo;
          valid_d = &cart_address[6:3];
          state_d = StCommit;
        end else begin
          state_d = StIdle;
        end
      end
      StCommit: begin
        commit_we = valid_q && !locked;
        state_d   = StRelease;
      end
      StRelease: begin
        if (!wr_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ctrl_d = ctrl_q;
    slot_d = slot_q;
    stb_d  = commit_we;
    if (commit_we) begin
      if (idx_q == 3'd0) begin
        ctrl_d = data_q[CtrlW-1:0];
      end
      for (int unsigned i = 1; i < 8; i++) begin
        if (idx_q == 3'(i)) slot_d[i] = data_q[BANK_W-1:0];
      end
    end
  end

  always_ff @(posedge vclk or negedge vres) begin
    if (!vres) begin
      state_q <= StIdle;
      sync_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      stb_q   <= 1'b0;
      ctrl_q  <= '0;
      for (int unsigned i = 1; i < 8; i++) begin
        slot_q[i] <= (RESET_IDENTITY != 0) ? BANK_W'(i) : '0;
      end
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      stb_q   <= stb_d;
      ctrl_q  <= ctrl_d;
      slot_q  <= slot_d;
    end
  end

  // Slot 0 has no register and always maps bank 0.
  always_comb begin
    rom_bank = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (slot_sel == 3'(i)) rom_bank = slot_q[i];
    end
  end

  assign sram_en     = ctrl_q[0];
  assign bank_wr_stb = stb_q;
  assign bank_wr_idx = idx_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: doc/ssf_bank_ctrl.md
Name: ssf_bank_ctrl

Overview:
Bank-register controller for the SSF-style cartridge mapper. Qualifies 68K lower-byte writes in the /TIME space ($A130F1–$A130FF) with a synchronising, glitch-filtering write FSM, and commits them to seven 8-bit bank registers plus one SRAM control register. Drives the upper ROM address bits (rom_bank) combinationally from the currently addressed 512 KB slot. Sits between the cartridge edge connector and the flash/SRAM chip-select and address logic.

Parameters:
BANK_W, 8, bank register width (1..8); writes use data bits [BANK_W-1:0].
SYNC_STAGES, 2, synchroniser depth for tme/lwr (minimum 2).
RESET_IDENTITY, 1, 1: slot n resets to bank n; 0: all slots reset to 0.

Ports:
vclk  input  1  68K clock; all state on rising edge.
vres  input  1  system reset, asynchronous, active-low.
tme  input  1  /TIME strobe, active-low, asynchronous to vclk.
lwr  input  1  /LWR strobe, active-low, asynchronous to vclk.
cart_address  input  23  68K word address A1..A23.
cart_data_lo  input  8  68K data bus lower byte D7..D0.
rom_bank  output  BANK_W  bank number for slot cart_address A21..A19.
sram_en  output  1  SRAM mapped in (from $A130F1 bit 0).
bank_wr_stb  output  1  one-cycle pulse per committed register write.
bank_wr_idx  output  3  register index of the write in progress; valid with bank_wr_stb.
busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (vres low, async): FSM to IDLE; slot n register = n if RESET_IDENTITY else 0; sram_en=0; bank_wr_stb=0; bank_wr_idx=0; busy=0; synchronisers cleared to inactive.
- Strobe: wr_req = (tme low AND lwr low), passed through SYNC_STAGES flops → wr_s.
- Decode: register index = A3..A1. Access is valid only when A7..A4 = 4'b1111.
- FSM:
  - IDLE: wr_s → QUAL.
  - QUAL: wr_s still set → capture index and cart_data_lo, go to COMMIT. Otherwise → IDLE with no write (glitch reject; strobe must be seen on 2 consecutive synced samples).
  - COMMIT: write the captured register if decode is valid; assert bank_wr_stb for this cycle only; → RELEASE. If decode is invalid, perform no write and no pulse, but still → RELEASE.
  - RELEASE: hold until wr_s clears → IDLE. Guarantees exactly one commit per strobe assertion regardless of hold length.
- Latency (SYNC_STAGES=2): register value and rom_bank update at the 4th rising vclk edge after the first edge that samples wr_req active.
- Index 1..7: slot register written with data[BANK_W-1:0].
- Index 0: SRAM control register ($A130F1). sram_en = bit 0.
- Slot 0 is never writable; rom_bank reads 0 for slot 0.
- rom_bank = slot register selected by A21..A19. It is purely combinational, so a committed write is visible on the same edge the register updates.
- Simultaneous read of a slot and commit to that slot: rom_bank switches at the commit edge, with no intermediate value.
- A strobe that drops during QUAL produces no write. A new strobe during RELEASE is merged with the current one.
- vres asserted in any state aborts the operation and restores the reset values immediately.

Optional Feature:
SSF_SRAM_WP_EN
- Defined: adds output sram_wp (1 bit, reset 0) = $A130F1 bit 1.
- Defined and sram_wp=1: writes to index 1..7 are suppressed, with no register change and no bank_wr_stb. Index 0 remains writable so the lock can be released.
- Undefined: no sram_wp port; bit 1 is ignored; bank writes are never locked.

Test Plan:
- Reset with RESET_IDENTITY=1 → A21..A19=0..7 reads rom_bank 0,1,..,7. sram_en=0, busy=0.
- tme=lwr=0 for 6 cycles, A7..A1=7'b1111_010, data=0x1F → single bank_wr_stb with idx=2. Then A21..A19=2 → rom_bank=0x1F, and rom_bank changes exactly 4 edges after the first synced sample.
- 1-cycle low pulse on tme/lwr (synced wr_s high for 1 cycle only) → no bank_wr_stb, all registers unchanged.
- Strobe held 40 cycles, then re-asserted after release, with data 0x05 then 0x06 to idx 7 → exactly two pulses, final slot 7=0x06. Address A7..A4=4'b1110 → no pulse, no change.
- vres pulsed low while FSM is in COMMIT, after slot 3 was written 0xAA → slot 3=3, busy=0 immediately, no pulse.
- SSF_SRAM_WP_EN defined: write 0x03 to idx 0 → sram_en=1, sram_wp=1. Then write 0x44 to idx 1 → slot 1 stays 1, no pulse. Then write 0x00 to idx 0 → sram_wp=0.
